// File: rtl/iodelay_tap_calib_pkg.sv
`default_nettype none
// iodelay_tap_calib_pkg: FSM encoding and tap-range constants shared by the calibration block.
// Rev 1.0
package iodelay_tap_calib_pkg;

   localparam int NUM_TAPS = 32;
   localparam int TAP_W    = 5;

   typedef logic [TAP_W-1:0] tap_t;
   typedef logic [TAP_W:0]   tgt_t;

   localparam tap_t MAX_TAP        = tap_t'(NUM_TAPS - 1);
   localparam tgt_t NO_EDGE_TARGET = tgt_t'(16);

   typedef enum logic [3:0] {
      IDLE,
      ZERO,
      SETTLE,
      SAMPLE,
      STEP,
      REWIND,
      SEEK,
      FIN
   } state_t;

endpackage
`default_nettype wire

// File: rtl/iodelay_sample_vote.sv
`default_nettype none
// iodelay_sample_vote: counts ones of data_in over SAMPLES enabled cycles and reports the majority.
// Rev 1.0
module iodelay_sample_vote #(
   parameter int SAMPLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   input  logic data_in,
   output logic valid,
   output logic vote_bit
);

   localparam int CW = $clog2(SAMPLES) + 1;

   logic [CW-1:0] sample_cnt;
   logic [CW-1:0] ones_cnt;
   logic [CW-1:0] ones_total;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sample_cnt <= '0;
         ones_cnt   <= '0;
      end else if (en) begin
         sample_cnt <= sample_cnt + CW'(1);
         ones_cnt   <= ones_total;
      end
   end

   // The decision includes the sample being taken this cycle, so it is ready on the last one.
   assign ones_total = ones_cnt + CW'(data_in);
   assign valid      = en && (sample_cnt == CW'(SAMPLES - 1));
   assign vote_bit   = ones_total > CW'(SAMPLES / 2);

endmodule
`default_nettype wire

// File: rtl/iodelay_tap_calib.sv
`default_nettype none
// iodelay_tap_calib: sweeps a 32-tap delay line for a data transition, then seeks edge+offset.
// Rev 1.0
module iodelay_tap_calib
   import iodelay_tap_calib_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLES       = 16,
   parameter int TAP_OFFSET    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step_req,
   input  logic             data_in,
   output logic             dly_rst,
   output logic             dly_ce,
   output logic             dly_inc,
   output logic [TAP_W-1:0] tap_value,
   output logic             busy,
   output logic             done,
   output logic             edge_found,
   output logic [TAP_W-1:0] edge_tap
);

   localparam int   SW   = $clog2(SETTLE_CYCLES + 1);
   localparam tgt_t OFFS = (TAP_OFFSET > NUM_TAPS - 1) ? tgt_t'(NUM_TAPS - 1) : tgt_t'(TAP_OFFSET);

   state_t        state, state_nxt;
   tap_t          tap_nxt, edge_tap_nxt;
   tgt_t          target, target_nxt, seek_sum, target_calc;
   logic [SW-1:0] settle_cnt, settle_nxt;
   logic          rst_nxt, ce_nxt, busy_nxt, done_nxt, found_nxt;
   logic          ref_bit, ref_nxt;
   logic          vote_valid, vote_bit;

   iodelay_sample_vote #(
      .SAMPLES (SAMPLES)
   ) u_vote (
      .clk      (clk),
      .rst      (rst),
      .clear    (state != SAMPLE),
      .en       (state == SAMPLE),
      .data_in  (data_in),
      .valid    (vote_valid),
      .vote_bit (vote_bit)
   );

   // Both operands are at most 31, so the 6-bit sum cannot wrap before saturation.
   assign seek_sum    = {1'b0, edge_tap} + OFFS;
   assign target_calc = !edge_found ? NO_EDGE_TARGET :
                        (seek_sum > tgt_t'(MAX_TAP)) ? tgt_t'(MAX_TAP) : seek_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dly_rst    <= 1'b1;
         dly_ce     <= 1'b0;
         dly_inc    <= 1'b0;
         tap_value  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         edge_found <= 1'b0;
         edge_tap   <= '0;
         ref_bit    <= 1'b0;
         target     <= '0;
         settle_cnt <= '0;
      end else begin
         state      <= state_nxt;
         dly_rst    <= rst_nxt;
         dly_ce     <= ce_nxt;
         dly_inc    <= ce_nxt;
         tap_value  <= tap_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         edge_found <= found_nxt;
         edge_tap   <= edge_tap_nxt;
         ref_bit    <= ref_nxt;
         target     <= target_nxt;
         settle_cnt <= settle_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tap_nxt      = tap_value;
      rst_nxt      = 1'b0;
      ce_nxt       = 1'b0;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      found_nxt    = edge_found;
      edge_tap_nxt = edge_tap;
      ref_nxt      = ref_bit;
      target_nxt   = target;
      settle_nxt   = settle_cnt;
      case (state)
         IDLE: begin
            if (start) begin
               rst_nxt      = 1'b1;
               tap_nxt      = '0;
               busy_nxt     = 1'b1;
               found_nxt    = 1'b0;
               edge_tap_nxt = '0;
               state_nxt    = ZERO;
            end else if (step_req) begin
               ce_nxt  = 1'b1;
               tap_nxt = tap_value + tap_t'(1);
            end
         end
         ZERO, STEP: begin
            settle_nxt = '0;
            state_nxt  = SETTLE;
         end
         SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
               state_nxt = SAMPLE;
            end else begin
               settle_nxt = settle_cnt + SW'(1);
            end
         end
         SAMPLE: begin
            if (vote_valid) begin
               if (tap_value == '0) begin
                  ref_nxt = vote_bit;
               end
               if ((tap_value != '0) && (vote_bit != ref_bit)) begin
                  found_nxt    = 1'b1;
                  edge_tap_nxt = tap_value;
                  rst_nxt      = 1'b1;
                  tap_nxt      = '0;
                  state_nxt    = REWIND;
               end else if (tap_value == MAX_TAP) begin
                  rst_nxt   = 1'b1;
                  tap_nxt   = '0;
                  state_nxt = REWIND;
               end else begin
                  ce_nxt    = 1'b1;
                  tap_nxt   = tap_value + tap_t'(1);
                  state_nxt = STEP;
               end
            end
         end
         REWIND: begin
            target_nxt = target_calc;
            if (target_calc == '0) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = FIN;
            end else begin
               ce_nxt    = 1'b1;
               tap_nxt   = tap_t'(1);
               state_nxt = SEEK;
            end
         end
         SEEK: begin
            if ({1'b0, tap_value} == target) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = FIN;
            end else begin
               ce_nxt  = 1'b1;
               tap_nxt = tap_value + tap_t'(1);
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/iodelay_tap_calib.md
IODELAY_TAP_CALIB -- requirements
Module: iodelay_tap_calib

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: idle cycles after any tap change before sampling.
REQ-002 SHALL have parameter SAMPLES, default 16: samples of data_in taken per tap (power of two, 2..256).
REQ-003 SHALL have parameter TAP_OFFSET, default 8: taps added to the detected edge to give the final tap.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic; also drives the delay element C pin.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a calibration sweep.
REQ-007 SHALL have port step_req, input, 1 bit: one-cycle pulse requesting a single manual +1 tap (DIP-switch calibration path).
REQ-008 SHALL have port data_in, input, 1 bit: delayed signal from the delay element, already synchronous to clk.
REQ-009 SHALL have ports dly_rst, dly_ce and dly_inc, each output, 1 bit: RST, CE and INC for the variable delay element.
REQ-010 SHALL have port tap_value, output, 5 bits: current tap as tracked by the controller.
REQ-011 SHALL have ports busy and done, each output, 1 bit: busy = sweep in progress; done = one-cycle completion pulse.
REQ-012 SHALL have ports edge_found, output, 1 bit, and edge_tap, output, 5 bits: result of the last sweep.

Function
REQ-013 SHALL implement FSM states IDLE, ZERO, SETTLE, SAMPLE, STEP, REWIND, SEEK and FIN; all outputs SHALL be registered.
REQ-014 IDLE + start: SHALL pulse dly_rst for 1 cycle, set tap_value=0, set busy=1, clear edge_found/edge_tap, and go to ZERO then SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-016 SAMPLE SHALL count ones of data_in over exactly SAMPLES cycles; the tap bit SHALL be 1 iff ones > SAMPLES/2 (ties give 0).
REQ-017 The tap-0 bit SHALL be stored as the reference bit.
REQ-018 At tap>0, the first bit that differs from the reference SHALL set edge_found=1 and edge_tap=tap_value, then go to REWIND.
REQ-019 No difference with tap<31 SHALL go to STEP; no difference at tap 31 SHALL go to REWIND with edge_found=0.
REQ-020 STEP SHALL assert dly_ce=1 and dly_inc=1 for exactly 1 cycle, increment tap_value, then go to SETTLE.
REQ-021 REWIND SHALL pulse dly_rst for 1 cycle and set tap_value=0.
REQ-022 REWIND SHALL compute the target as min(edge_tap+TAP_OFFSET, 31) when edge_found=1, else 16, using 6-bit arithmetic with no wrap.
REQ-023 SEEK SHALL assert dly_ce=dly_inc=1 on consecutive cycles, incrementing tap_value each cycle, until tap_value==target; a target of 0 SHALL give zero CE pulses.
REQ-024 FIN SHALL pulse done for 1 cycle, clear busy, and return to IDLE; total CE pulses in SEEK SHALL equal target.
REQ-025 step_req in IDLE SHALL give one dly_ce/dly_inc pulse the next cycle, with tap_value wrapping 31->0.
REQ-026 start and step_req asserted in the same IDLE cycle: start SHALL win and step_req SHALL be dropped.
REQ-027 start and step_req while busy=1 SHALL be ignored, not queued.
REQ-028 dly_rst and dly_ce SHALL never be asserted in the same cycle.
REQ-029 dly_inc SHALL be 1 whenever dly_ce is 1, and 0 otherwise.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE; dly_rst=1; dly_ce=dly_inc=0; tap_value=0; busy=done=edge_found=0; edge_tap=0; all counters 0.
REQ-031 dly_rst SHALL deassert on the first clock edge with rst=0, so the element is re-zeroed after any reset, including a reset mid-sweep.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, NUM_TAPS=32, TAP_W=5 and the no-edge default target of 16.
REQ-033 One sub-module, iodelay_sample_vote, SHALL own the SAMPLES counter and majority decision.
REQ-034 iodelay_sample_vote SHALL have inputs clk, rst, clear, en and data_in; outputs SHALL be valid and bit.

Verification
REQ-035 Edge found: data_in=0 for taps 0..11 and 1 from tap 12 -> edge_found=1, edge_tap=12, final tap_value=20, 20 CE pulses in SEEK, one done pulse.
REQ-036 Saturation: edge at tap 28 -> target 31, tap_value=31.
REQ-037 No edge: data_in held 1 for the whole sweep -> edge_found=0, tap_value=16; sweep length = 32*(8+16) + 31 STEP + seek/overhead cycles, checked exactly.
REQ-038 Noise: 7 ones in 16 samples -> bit 0; 9 ones -> bit 1; 8 ones -> bit 0.
REQ-039 Manual steps and collisions: 33 step_req pulses in IDLE -> tap_value=1 after wrap; start+step_req in the same cycle -> sweep runs and no extra CE; step_req during busy -> CE count unchanged.
REQ-040 Reset at tap 7 mid-SETTLE -> next cycle dly_rst=1, busy=0, tap_value=0; a new start then completes normally.
